// File: rtl/barrel_shift_sched_if.sv
// Request/response channels for two clients plus the shared 4-bit shifter hookup.
// slave = scheduler side, master = client/shifter side.
interface barrel_shift_sched_if #(
  parameter int DATA_W = 4,
  parameter int AMT_W  = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_dir;
  logic [1:0]        req0_mode;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_dir;
  logic [1:0]        req1_mode;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  logic [DATA_W-1:0] sh_data_in;
  logic [1:0]        sh_amt;
  logic              sh_dir;
  logic [1:0]        sh_mode;
  logic [DATA_W-1:0] sh_data_out;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir, req0_mode,
    input  req1_valid, req1_data, req1_amt, req1_dir, req1_mode,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output sh_data_in, sh_amt, sh_dir, sh_mode, busy,
    input  sh_data_out
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir, req0_mode,
    output req1_valid, req1_data, req1_amt, req1_dir, req1_mode,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err, rsp1_valid, rsp1_data, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  sh_data_in, sh_amt, sh_dir, sh_mode, busy,
    output sh_data_out
  );
endinterface

// File: rtl/barrel_shift_sched.sv
// Round-robin shares one 0-3 bit shifter between two clients, iterating passes for 0-15 shifts.
// Latency P+1 cycles from accept (P = shifter passes); one job at a time, result held until taken.
module barrel_shift_sched #(
  parameter int DATA_W = 4,
  parameter int AMT_W  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  barrel_shift_sched_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_PASS, S_RESP} state_t;

  state_t            r_state;
  logic              r_rr_ptr;
  logic [DATA_W-1:0] r_acc;
  logic [AMT_W-1:0]  r_rem;
  logic              r_dir;
  logic [1:0]        r_mode;
  logic              r_id;
  logic              r_err;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;

  logic              w_take;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_id;
  logic [DATA_W-1:0] w_in_data;
  logic [AMT_W-1:0]  w_in_amt;
  logic [AMT_W-1:0]  w_in_rem;
  logic              w_in_dir;
  logic [1:0]        w_in_mode;
  logic [1:0]        w_step;
  logic [AMT_W-1:0]  w_rem_next;
  logic              w_pass;
  logic              w_rsp_hs;

  assign w_take = rst_n && (r_state == S_IDLE);
  assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
  assign w_gnt1 = bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
  assign bus.req0_ready = w_take && w_gnt0;
  assign bus.req1_ready = w_take && w_gnt1;

  assign w_id      = bus.req1_ready;
  assign w_in_data = w_id ? bus.req1_data : bus.req0_data;
  assign w_in_amt  = w_id ? bus.req1_amt  : bus.req0_amt;
  assign w_in_dir  = w_id ? bus.req1_dir  : bus.req0_dir;
  assign w_in_mode = w_id ? bus.req1_mode : bus.req0_mode;
  // Rotation is periodic in the width, so only amt mod 4 needs a pass.
  assign w_in_rem  = (w_in_mode == 2'b01) ? {{(AMT_W-2){1'b0}}, w_in_amt[1:0]} : w_in_amt;

  // The shifter's arithmetic-right path moves exactly one bit regardless of sh_amt.
  assign w_step = (r_mode == 2'b10 && r_dir) ? 2'd1 :
                  (r_rem > AMT_W'(3))        ? 2'd3 : r_rem[1:0];
  assign w_rem_next = r_rem - AMT_W'(w_step);
  assign w_pass     = (r_state == S_PASS);

  assign bus.sh_data_in = w_pass ? r_acc  : '0;
  assign bus.sh_amt     = w_pass ? w_step : 2'd0;
  assign bus.sh_dir     = w_pass && r_dir;
  assign bus.sh_mode    = w_pass ? r_mode : 2'd0;
  assign bus.busy       = (r_state != S_IDLE);

  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = r_acc;
  assign bus.rsp1_data  = r_acc;
  assign bus.rsp0_err   = r_err;
  assign bus.rsp1_err   = r_err;
  assign w_rsp_hs = (r_rsp0_valid && bus.rsp0_ready) || (r_rsp1_valid && bus.rsp1_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= 1'b0;
      r_acc        <= '0;
      r_rem        <= '0;
      r_dir        <= 1'b0;
      r_mode       <= 2'd0;
      r_id         <= 1'b0;
      r_err        <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0_ready || bus.req1_ready) begin
            r_id     <= w_id;
            r_rr_ptr <= ~w_id;
            r_dir    <= w_in_dir;
            r_mode   <= w_in_mode;
            if (w_in_mode == 2'b11) begin
              r_acc   <= '0;
              r_rem   <= '0;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_acc   <= w_in_data;
              r_rem   <= w_in_rem;
              r_err   <= 1'b0;
              r_state <= (w_in_rem == '0) ? S_RESP : S_PASS;
            end
          end
        end
        S_PASS: begin
          r_acc <= bus.sh_data_out;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) r_state <= S_RESP;
        end
        S_RESP: begin
          // First RESP cycle raises the response; it then holds until the handshake.
          if (!r_rsp0_valid && !r_rsp1_valid) begin
            r_rsp0_valid <= !r_id;
            r_rsp1_valid <= r_id;
          end else if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barrel_shift_sched.sv
// Bench for barrel_shift_sched: models the 4-bit shifter and scoreboards expected responses.
module tb_barrel_shift_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct {
    logic       id;
    logic [3:0] data;
    logic       err;
    int         lat;
    int         t_acc;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] sh_seen[$];

  barrel_shift_sched_if bus ();
  barrel_shift_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.busy && bus.sh_amt != 2'd0) sh_seen.push_back(bus.sh_amt);

  // Single-pass shifter: 0-3 bits, arithmetic right always moves one bit.
  function automatic logic [3:0] sh_model(logic [3:0] d, logic [1:0] a, logic dir, logic [1:0] m);
    logic [7:0] t;
    case (m)
      2'b01: begin
        if (dir) begin t = {d, d} >> a; return t[3:0]; end
        else begin t = {d, d} << a; return t[7:4]; end
      end
      2'b10:   return dir ? {d[3], d[3:1]} : (d << a);
      default: return dir ? (d >> a) : (d << a);
    endcase
  endfunction

  assign bus.sh_data_out = sh_model(bus.sh_data_in, bus.sh_amt, bus.sh_dir, bus.sh_mode);

  function automatic logic [3:0] ref_result(logic [3:0] d, logic [3:0] amt, logic dir, logic [1:0] mode);
    logic [7:0]        t;
    logic signed [3:0] s;
    logic signed [3:0] r;
    case (mode)
      2'b01: begin
        if (dir) begin t = {d, d} >> amt[1:0]; return t[3:0]; end
        else begin t = {d, d} << amt[1:0]; return t[7:4]; end
      end
      2'b10: begin
        s = d;
        r = s >>> amt;
        if (dir) return r;
        return (amt >= 4'd4) ? 4'd0 : (d << amt);
      end
      2'b11:   return 4'd0;
      default: begin
        if (amt >= 4'd4) return 4'd0;
        return dir ? (d >> amt) : (d << amt);
      end
    endcase
  endfunction

  function automatic int ref_passes(logic [3:0] amt, logic dir, logic [1:0] mode);
    case (mode)
      2'b01:   return (amt[1:0] != 2'd0) ? 1 : 0;
      2'b10:   return dir ? int'(amt) : (int'(amt) + 2) / 3;
      2'b11:   return 0;
      default: return (int'(amt) + 2) / 3;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
  endtask

  // Presents one request (called at posedge+1), waits for acceptance, pushes the expectation.
  task automatic send(input logic id, input logic [3:0] d, input logic [3:0] amt,
                      input logic dir, input logic [1:0] mode, output bit ok);
    exp_t e;
    ok = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_amt = amt;
      bus.req1_dir = dir; bus.req1_mode = mode;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_amt = amt;
      bus.req0_dir = dir; bus.req0_mode = mode;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout id=%0d: ready never seen, required within 50 cycles", id);
      return;
    end
    sh_seen.delete();
    e.id = id;
    e.data = ref_result(d, amt, dir, mode);
    e.err = (mode == 2'b11);
    e.lat = ref_passes(amt, dir, mode) + 1;
    e.t_acc = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_rsp(input logic id, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (id ? bus.rsp1_valid : bus.rsp0_valid) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    vectors++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy/rsp0/rsp1/rdy0=%b required 0000",
               {bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready});
    end
    vectors++;
    if ({bus.sh_data_in, bus.sh_amt, bus.sh_dir, bus.sh_mode} !== 9'b0) begin
      errors++;
      $display("FAIL reset_sh sh_*=%b required 0", {bus.sh_data_in, bus.sh_amt, bus.sh_dir, bus.sh_mode});
    end
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [3:0] t_data [4];
    logic [3:0] t_amt  [4];
    logic [1:0] t_mode [4];
    logic [3:0] t_exp  [4];
    logic       t_dir  [4];
    logic       t_id   [4];
    logic [7:0] t_seq  [4];
    logic [7:0] obs;
    bit ok, seen;
    exp_t e;
    t_id   = '{1'b0, 1'b1, 1'b0, 1'b0};
    t_data = '{4'b1100, 4'b1001, 4'b1000, 4'b1011};
    t_amt  = '{4'd2, 4'd6, 4'd3, 4'd5};
    t_dir  = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_mode = '{2'b00, 2'b01, 2'b10, 2'b00};
    t_exp  = '{4'b0011, 4'b0110, 4'b1111, 4'b0000};
    // {pass count, pass amounts in order}
    t_seq  = '{8'h12, 8'h12, 8'h35, 8'h2E};
    for (int v = 0; v < 4; v++) begin
      send(t_id[v], t_data[v], t_amt[v], t_dir[v], t_mode[v], ok);
      if (!ok) continue;
      wait_rsp(t_id[v], seen);
      e = sbq.pop_front();
      vectors++;
      if (!seen) begin
        errors++;
        $display("FAIL dir%0d_rsp_timeout no response, required latency %0d", v, e.lat);
        do_reset();
        continue;
      end
      obs = 8'(sh_seen.size()) << 4;
      for (int k = 0; k < sh_seen.size(); k++) obs = obs | (8'(sh_seen[k]) << (2 * (sh_seen.size() - 1 - k)));
      if ((t_id[v] ? bus.rsp1_data : bus.rsp0_data) !== t_exp[v]) begin
        errors++;
        $display("FAIL dir%0d_data got %b required %b", v, t_id[v] ? bus.rsp1_data : bus.rsp0_data, t_exp[v]);
      end
      vectors++;
      if ((cyc - e.t_acc) != e.lat || (t_id[v] ? bus.rsp1_err : bus.rsp0_err) !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_lat_err lat=%0d err=%b required lat=%0d err=0", v, cyc - e.t_acc,
                 t_id[v] ? bus.rsp1_err : bus.rsp0_err, e.lat);
      end
      vectors++;
      if (obs !== t_seq[v]) begin
        errors++;
        $display("FAIL dir%0d_passes got %h required %h", v, obs, t_seq[v]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    bit   leak, seen;
    exp_t e;
    do_reset();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b1010; bus.req0_amt = 4'd1; bus.req0_dir = 1'b0; bus.req0_mode = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_data = 4'b0101; bus.req1_amt = 4'd1; bus.req1_dir = 1'b1; bus.req1_mode = 2'b00;
    @(negedge clk);
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL arb_first ready0/1=%b required 10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    e.id = 1'b0; e.data = 4'b0100; e.err = 1'b0; e.lat = 2; e.t_acc = cyc;
    sbq.push_back(e);
    leak = 1'b0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.req1_ready) leak = 1'b1;
      seen = bus.rsp0_valid;
    end
    e = sbq.pop_front();
    vectors++;
    if (!seen || bus.rsp0_data !== e.data || (cyc - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL arb_rsp0 seen=%b data=%b lat=%0d required seen=1 data=%b lat=%0d",
               seen, bus.rsp0_data, cyc - e.t_acc, e.data, e.lat);
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      if (bus.req1_ready) leak = 1'b1;
      vectors++;
      if ({bus.rsp0_valid, bus.rsp0_data} !== {1'b1, e.data}) begin
        errors++;
        $display("FAIL arb_hold%0d valid/data=%b required 1%b", h, {bus.rsp0_valid, bus.rsp0_data}, e.data);
      end
    end
    vectors++;
    if (leak) begin
      errors++;
      $display("FAIL arb_req1_blocked req1_ready=1 seen while busy, required 0");
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.rsp0_valid, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL arb_second rsp0_valid/req1_ready=%b required 01", {bus.rsp0_valid, bus.req1_ready});
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    e.id = 1'b1; e.data = 4'b0010; e.err = 1'b0; e.lat = 2; e.t_acc = cyc;
    sbq.push_back(e);
    wait_rsp(1'b1, seen);
    e = sbq.pop_front();
    vectors++;
    if (!seen || bus.rsp1_data !== e.data || (cyc - e.t_acc) != e.lat) begin
      errors++;
      $display("FAIL arb_rsp1 seen=%b data=%b lat=%0d required seen=1 data=%b lat=%0d",
               seen, bus.rsp1_data, cyc - e.t_acc, e.data, e.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_and_reset();
    bit   ok, seen, stray;
    exp_t e;
    send(1'b1, 4'b1010, 4'd7, 1'b0, 2'b11, ok);
    if (ok) begin
      wait_rsp(1'b1, seen);
      e = sbq.pop_front();
      vectors++;
      if (!seen || {bus.rsp1_err, bus.rsp1_data} !== {e.err, e.data} || (cyc - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL illegal seen=%b err/data=%b lat=%0d required err/data=%b lat=%0d",
                 seen, {bus.rsp1_err, bus.rsp1_data}, cyc - e.t_acc, {e.err, e.data}, e.lat);
      end
      @(posedge clk); #1;
    end
    send(1'b0, 4'b1111, 4'd15, 1'b0, 2'b00, ok);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_mode = 2'b00;
    @(posedge clk); #1;
    vectors++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, bus.sh_data_in, bus.sh_amt} !== 10'b0) begin
      errors++;
      $display("FAIL midpass_reset busy/rsp0/rsp1/rdy1/shdat/shamt=%b required 0",
               {bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, bus.sh_data_in, bus.sh_amt});
    end
    if (ok) void'(sbq.pop_front());
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      errors++;
      $display("FAIL abandoned_job activity after reset, required none");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit   ok, seen;
    exp_t e;
    logic id, dir;
    logic [3:0] d, amt;
    logic [1:0] mode;
    for (int v = 0; v < 24; v++) begin
      id = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15)); amt = 4'($urandom_range(0, 15));
      mode = (v % 8 == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      send(id, d, amt, dir, mode, ok);
      if (!ok) continue;
      wait_rsp(id, seen);
      e = sbq.pop_front();
      vectors++;
      if (!seen) begin
        errors++;
        $display("FAIL rand%0d_timeout no response, required latency %0d", v, e.lat);
        do_reset();
        continue;
      end
      if ({(id ? bus.rsp1_err : bus.rsp0_err), (id ? bus.rsp1_data : bus.rsp0_data)} !== {e.err, e.data}
          || (cyc - e.t_acc) != e.lat) begin
        errors++;
        $display("FAIL rand%0d id=%0d d=%b amt=%0d dir=%0d mode=%0d err/data=%b lat=%0d required %b lat=%0d",
                 v, id, d, amt, dir, mode,
                 {(id ? bus.rsp1_err : bus.rsp0_err), (id ? bus.rsp1_data : bus.rsp0_data)},
                 cyc - e.t_acc, {e.err, e.data}, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_dir = 1'b0; bus.req0_mode = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_dir = 1'b0; bus.req1_mode = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    test_reset();
    test_vectors();
    test_arbitration();
    test_illegal_and_reset();
    test_back_to_back();
    vectors++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain %0d entries left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
